// File: rtl/melody_sequencer_if.sv
// Control/status bundle between game logic and the melody sequencer.
// master: game side (play_req, melody_sel, stop); slave: sequencer (tone, enable_sound, busy, done).
interface melody_sequencer_if;
    logic       play_req;
    logic [1:0] melody_sel;
    logic       stop;
    logic [3:0] tone;
    logic       enable_sound;
    logic       busy;
    logic       done;

    modport master (
        output play_req,
        output melody_sel,
        output stop,
        input  tone,
        input  enable_sound,
        input  busy,
        input  done
    );

    modport slave (
        input  play_req,
        input  melody_sel,
        input  stop,
        output tone,
        output enable_sound,
        output busy,
        output done
    );
endinterface

// File: rtl/melody_sequencer.sv
// Jingle player: steps a 4x8 note ROM, holding each note dur*UNIT_CYCLES cycles.
// Ports: clk, reset (sync, active-high), bus (slave: play_req/melody_sel/stop in; tone/enable_sound/busy/done out).
module melody_sequencer #(
    parameter int unsigned UNIT_CYCLES = 630_000,
    parameter int unsigned GAP_CYCLES  = 31_500
) (
    input  logic               clk,
    input  logic               reset,
    melody_sequencer_if.slave  bus
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sel;
    logic [2:0]      r_idx;
    logic            r_end;
    logic            r_rest;
    logic [5:0]      r_dur;
    logic [3:0]      r_tone;
    logic [CW-1:0]   r_cyc;
    logic [5:0]      r_unit;
    logic [GW-1:0]   r_gap;
    logic            r_done;

    logic [11:0]     w_word;
    logic [5:0]      w_unit_last;
    logic            w_note_last;
    logic            w_is_end;
    logic            w_gap_last;
    logic            w_start;
    logic            w_adv;
    logic            w_fin;

    // Word layout: {end, rest, dur[5:0], tone[3:0]}
    function automatic logic [11:0] rom(input logic [4:0] a);
        case (a)
            5'd0:    rom = {1'b0, 1'b0, 6'd2, 4'd0};
            5'd1:    rom = {1'b0, 1'b0, 6'd2, 4'd4};
            5'd2:    rom = {1'b0, 1'b0, 6'd2, 4'd7};
            5'd3:    rom = {1'b1, 1'b0, 6'd4, 4'd12};
            5'd8:    rom = {1'b0, 1'b0, 6'd1, 4'd12};
            5'd9:    rom = {1'b0, 1'b0, 6'd1, 4'd9};
            5'd10:   rom = {1'b0, 1'b0, 6'd1, 4'd5};
            5'd11:   rom = {1'b1, 1'b0, 6'd3, 4'd0};
            5'd16:   rom = {1'b0, 1'b0, 6'd2, 4'd0};
            5'd17:   rom = {1'b0, 1'b0, 6'd2, 4'd4};
            5'd18:   rom = {1'b0, 1'b0, 6'd2, 4'd7};
            5'd19:   rom = {1'b0, 1'b0, 6'd2, 4'd12};
            5'd20:   rom = {1'b0, 1'b1, 6'd1, 4'd0};
            5'd21:   rom = {1'b0, 1'b0, 6'd1, 4'd7};
            5'd22:   rom = {1'b1, 1'b0, 6'd6, 4'd12};
            5'd24:   rom = {1'b0, 1'b0, 6'd3, 4'd7};
            5'd25:   rom = {1'b0, 1'b0, 6'd3, 4'd6};
            5'd26:   rom = {1'b0, 1'b0, 6'd3, 4'd5};
            5'd27:   rom = {1'b1, 1'b0, 6'd8, 4'd4};
            default: rom = 12'd0;
        endcase
    endfunction

    assign w_word      = rom({r_sel, r_idx});
    // A zero duration plays as one unit
    assign w_unit_last = (r_dur == 6'd0) ? 6'd0 : r_dur - 6'd1;
    assign w_note_last = (r_cyc == CYC_LAST) && (r_unit == w_unit_last);
    // The last slot of every melody terminates it regardless of its flag
    assign w_is_end    = r_end || (r_idx == 3'd7);
    assign w_gap_last  = (r_gap == GAP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_fin   = 1'b0;
        if (bus.stop) begin
            w_next = S_IDLE;
        end else if (bus.play_req) begin
            w_next  = S_LOAD;
            w_start = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_LOAD: w_next = S_PLAY;
                S_PLAY: begin
                    if (w_note_last) begin
                        if (w_is_end) begin
                            w_next = S_IDLE;
                            w_fin  = 1'b1;
                        end else begin
                            w_next = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_gap_last) begin
                        w_next = S_LOAD;
                        w_adv  = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel  <= 2'd0;
            r_idx  <= 3'd0;
            r_end  <= 1'b0;
            r_rest <= 1'b0;
            r_dur  <= 6'd0;
            r_tone <= 4'd0;
            r_cyc  <= '0;
            r_unit <= 6'd0;
            r_gap  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin;

            if (w_start) begin
                r_sel <= bus.melody_sel;
                r_idx <= 3'd0;
            end else if (w_adv && (r_idx != 3'd7)) begin
                r_idx <= r_idx + 3'd1;
            end

            case (r_state)
                S_LOAD: begin
                    r_end  <= w_word[11];
                    r_rest <= w_word[10];
                    r_dur  <= w_word[9:4];
                    r_tone <= w_word[3:0];
                    r_cyc  <= '0;
                    r_unit <= 6'd0;
                    r_gap  <= '0;
                end
                S_PLAY: begin
                    r_gap <= '0;
                    if (r_cyc == CYC_LAST) begin
                        r_cyc  <= '0;
                        r_unit <= r_unit + 6'd1;
                    end else begin
                        r_cyc <= r_cyc + CYC_ONE;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + GAP_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.tone         = r_tone;
    assign bus.enable_sound = (r_state == S_PLAY) && !r_rest;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer (UNIT_CYCLES=4, GAP_CYCLES=2).
// Cycle c is observed 1 ns after the c-th rising edge following the play request.
module tb_melody_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    melody_sequencer_if u_if ();

    melody_sequencer #(
        .UNIT_CYCLES(4),
        .GAP_CYCLES (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Expected sounding windows: [ws, we] inclusive with tone wt
    int ws[8];
    int we[8];
    int wt[8];
    int wn;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void win_at(input int c, output logic en, output logic [3:0] t);
        en = 1'b0;
        t  = 4'd0;
        for (int i = 0; i < wn; i++) begin
            if (c >= ws[i] && c <= we[i]) begin
                en = 1'b1;
                t  = 4'(wt[i]);
            end
        end
    endfunction

    function automatic void set_win(input int i, input int s, input int e, input int t);
        ws[i] = s;
        we[i] = e;
        wt[i] = t;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        u_if.play_req = 1'b0;
        u_if.stop = 1'b0;
        u_if.melody_sel = 2'd0;
        step();
        reset = 1'b0;
        u_if.play_req = 1'b1;
        u_if.melody_sel = 2'd1;
        step();
        u_if.play_req = 1'b0;
        repeat (4) step();
        n_run++;
        if (u_if.tone !== 4'd12 || u_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_play tone=%0d busy=%b expected tone=12 busy=1", u_if.tone, u_if.busy);
        end
        for (int k = 0; k < 3; k++) begin
            reset = 1'b1;
            u_if.play_req = 1'($urandom_range(0, 1));
            u_if.stop = 1'($urandom_range(0, 1));
            u_if.melody_sel = 2'($urandom_range(0, 3));
            step();
            n_run++;
            if ({u_if.tone, u_if.enable_sound, u_if.busy, u_if.done} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d tone=%0d en=%b busy=%b done=%b expected all 0",
                         k, u_if.tone, u_if.enable_sound, u_if.busy, u_if.done);
            end
        end
        reset = 1'b0;
        u_if.play_req = 1'b0;
        u_if.stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_run++;
            if ({u_if.tone, u_if.enable_sound, u_if.busy, u_if.done} !== 7'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle k=%0d tone=%0d en=%b busy=%b done=%b expected all 0",
                         k, u_if.tone, u_if.enable_sound, u_if.busy, u_if.done);
            end
        end
    endtask

    task automatic test_m0_play();
        logic e_en;
        logic [3:0] e_t;
        logic [2:0] e_v;
        wn = 4;
        set_win(0, 2, 9, 0);
        set_win(1, 13, 20, 4);
        set_win(2, 24, 31, 7);
        set_win(3, 35, 50, 12);
        for (int c = 0; c < 56; c++) begin
            win_at(c, e_en, e_t);
            e_v = {e_en, (c >= 1 && c <= 50), (c == 51)};
            n_run++;
            if ({u_if.enable_sound, u_if.busy, u_if.done} !== e_v) begin
                n_fail++;
                $display("FAIL m0_ctrl c=%0d en/busy/done=%b expected %b", c,
                         {u_if.enable_sound, u_if.busy, u_if.done}, e_v);
            end
            if (e_en) begin
                n_run++;
                if (u_if.tone !== e_t) begin
                    n_fail++;
                    $display("FAIL m0_tone c=%0d tone=%0d expected %0d", c, u_if.tone, e_t);
                end
            end
            if (c == 0) begin
                u_if.play_req = 1'b1;
                u_if.melody_sel = 2'd0;
            end
            step();
            u_if.play_req = 1'b0;
        end
    endtask

    task automatic test_m2_rest();
        logic e_en;
        logic [3:0] e_t;
        logic [2:0] e_v;
        wn = 6;
        set_win(0, 2, 9, 0);
        set_win(1, 13, 20, 4);
        set_win(2, 24, 31, 7);
        set_win(3, 35, 42, 12);
        set_win(4, 53, 56, 7);
        set_win(5, 60, 83, 12);
        for (int c = 0; c < 90; c++) begin
            win_at(c, e_en, e_t);
            e_v = {e_en, (c >= 1 && c <= 83), (c == 84)};
            n_run++;
            if ({u_if.enable_sound, u_if.busy, u_if.done} !== e_v) begin
                n_fail++;
                $display("FAIL m2_ctrl c=%0d en/busy/done=%b expected %b", c,
                         {u_if.enable_sound, u_if.busy, u_if.done}, e_v);
            end
            if (e_en) begin
                n_run++;
                if (u_if.tone !== e_t) begin
                    n_fail++;
                    $display("FAIL m2_tone c=%0d tone=%0d expected %0d", c, u_if.tone, e_t);
                end
            end
            if (c == 0) begin
                u_if.play_req = 1'b1;
                u_if.melody_sel = 2'd2;
            end
            step();
            u_if.play_req = 1'b0;
        end
    endtask

    task automatic test_stop();
        logic e_en;
        logic [3:0] e_t;
        logic [2:0] e_v;
        wn = 2;
        set_win(0, 2, 13, 7);
        set_win(1, 17, 20, 6);
        for (int c = 0; c < 60; c++) begin
            win_at(c, e_en, e_t);
            e_v = {e_en, (c >= 1 && c <= 20), 1'b0};
            n_run++;
            if ({u_if.enable_sound, u_if.busy, u_if.done} !== e_v) begin
                n_fail++;
                $display("FAIL stop_ctrl c=%0d en/busy/done=%b expected %b", c,
                         {u_if.enable_sound, u_if.busy, u_if.done}, e_v);
            end
            if (e_en) begin
                n_run++;
                if (u_if.tone !== e_t) begin
                    n_fail++;
                    $display("FAIL stop_tone c=%0d tone=%0d expected %0d", c, u_if.tone, e_t);
                end
            end
            if (c == 0) begin
                u_if.play_req = 1'b1;
                u_if.melody_sel = 2'd3;
            end
            if (c == 20) u_if.stop = 1'b1;
            step();
            u_if.play_req = 1'b0;
            u_if.stop = 1'b0;
        end
    endtask

    task automatic test_restart();
        logic e_en;
        logic [3:0] e_t;
        logic [2:0] e_v;
        int n_done = 0;
        wn = 5;
        set_win(0, 2, 5, 7);
        set_win(1, 7, 10, 12);
        set_win(2, 14, 17, 9);
        set_win(3, 21, 24, 5);
        set_win(4, 28, 39, 0);
        for (int c = 0; c < 50; c++) begin
            win_at(c, e_en, e_t);
            e_v = {e_en, (c >= 1 && c <= 39), (c == 40)};
            if (u_if.done === 1'b1) n_done++;
            n_run++;
            if ({u_if.enable_sound, u_if.busy, u_if.done} !== e_v) begin
                n_fail++;
                $display("FAIL restart_ctrl c=%0d en/busy/done=%b expected %b", c,
                         {u_if.enable_sound, u_if.busy, u_if.done}, e_v);
            end
            if (e_en) begin
                n_run++;
                if (u_if.tone !== e_t) begin
                    n_fail++;
                    $display("FAIL restart_tone c=%0d tone=%0d expected %0d", c, u_if.tone, e_t);
                end
            end
            if (c == 0) begin
                u_if.play_req = 1'b1;
                u_if.melody_sel = 2'd3;
            end
            if (c == 5) begin
                u_if.play_req = 1'b1;
                u_if.melody_sel = 2'd1;
            end
            step();
            u_if.play_req = 1'b0;
        end
        n_run++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL restart_done_count got %0d expected 1", n_done);
        end
    endtask

    task automatic test_stop_and_play();
        logic e_en;
        logic [3:0] e_t;
        logic [2:0] e_v;
        wn = 1;
        set_win(0, 2, 4, 0);
        for (int c = 0; c < 30; c++) begin
            win_at(c, e_en, e_t);
            e_v = {e_en, (c >= 1 && c <= 4), 1'b0};
            n_run++;
            if ({u_if.enable_sound, u_if.busy, u_if.done} !== e_v) begin
                n_fail++;
                $display("FAIL sp_ctrl c=%0d en/busy/done=%b expected %b", c,
                         {u_if.enable_sound, u_if.busy, u_if.done}, e_v);
            end
            if (c == 0) begin
                u_if.play_req = 1'b1;
                u_if.melody_sel = 2'd0;
            end
            if (c == 4) begin
                u_if.play_req = 1'b1;
                u_if.stop = 1'b1;
                u_if.melody_sel = 2'd2;
            end
            step();
            u_if.play_req = 1'b0;
            u_if.stop = 1'b0;
        end
        wn = 4;
        set_win(0, 2, 5, 12);
        set_win(1, 9, 12, 9);
        set_win(2, 16, 19, 5);
        set_win(3, 23, 34, 0);
        for (int c = 0; c < 40; c++) begin
            win_at(c, e_en, e_t);
            e_v = {e_en, (c >= 1 && c <= 34), (c == 35)};
            n_run++;
            if ({u_if.enable_sound, u_if.busy, u_if.done} !== e_v) begin
                n_fail++;
                $display("FAIL sp_replay_ctrl c=%0d en/busy/done=%b expected %b", c,
                         {u_if.enable_sound, u_if.busy, u_if.done}, e_v);
            end
            if (e_en) begin
                n_run++;
                if (u_if.tone !== e_t) begin
                    n_fail++;
                    $display("FAIL sp_replay_tone c=%0d tone=%0d expected %0d", c, u_if.tone, e_t);
                end
            end
            if (c == 0) begin
                u_if.play_req = 1'b1;
                u_if.melody_sel = 2'd1;
            end
            step();
            u_if.play_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_m0_play();
        repeat (3) step();
        test_m2_rest();
        repeat (3) step();
        test_stop();
        test_restart();
        repeat (3) step();
        test_stop_and_play();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
